// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - byte-serial data-memory responder for MEM-stage loads/stores
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
    parameter int NB_WIDTH = 32,
    parameter int NB_ADDR  = 9,
    parameter int NB_DATA  = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_we,
    input  logic [NB_WIDTH-1:0] i_req_addr,
    input  logic [NB_WIDTH-1:0] i_req_wdata,
    input  logic [2:0]          i_req_bhw,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [NB_WIDTH-1:0] o_rsp_rdata,
    output logic                o_rsp_err,
    output logic                o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [NB_DATA-1:0]  mem [0:(2**NB_ADDR)-1];

    logic [NB_ADDR-1:0]  addr_q;
    logic [NB_WIDTH-1:0] wdata_q;
    logic [NB_WIDTH-1:0] acc_q;
    logic [1:0]          last_idx_q;
    logic [1:0]          cnt_q;
    logic                we_q;
    logic                zext_q;
    logic                err_q;

    logic                req_hs;
    logic                req_err;
    logic [NB_ADDR-1:0]  ram_addr;
    logic [1:0]          byte_idx;
    logic [NB_WIDTH-1:0] wshift;
    logic [NB_DATA-1:0]  wbyte;
    logic [NB_WIDTH-1:0] load_ext;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^i_req_addr[NB_WIDTH-1:NB_ADDR];

    assign req_hs = (state_q == ST_IDLE) && i_req_valid;

`ifdef DMEM_ALIGN_CHECK_EN
    assign req_err = (i_req_bhw[1:0] == 2'b10)
                   || ((i_req_bhw[1:0] == 2'b01) && i_req_addr[0])
                   || ((i_req_bhw[1:0] == 2'b11) && (i_req_addr[1:0] != 2'b00));
`else
    assign req_err = (i_req_bhw[1:0] == 2'b10);
`endif

    // Address wraps naturally at the top of the RAM because the sum is NB_ADDR wide.
    assign ram_addr = addr_q + NB_ADDR'(cnt_q);
    assign byte_idx = last_idx_q - cnt_q;
    assign wshift   = wdata_q >> {byte_idx, 3'b000};
    assign wbyte    = wshift[NB_DATA-1:0];

    always_comb begin
        load_ext = acc_q;
        case (last_idx_q)
            2'd0: load_ext = zext_q ? {{(NB_WIDTH-8){1'b0}}, acc_q[7:0]}
                                    : {{(NB_WIDTH-8){acc_q[7]}}, acc_q[7:0]};
            2'd1: load_ext = zext_q ? {{(NB_WIDTH-16){1'b0}}, acc_q[15:0]}
                                    : {{(NB_WIDTH-16){acc_q[15]}}, acc_q[15:0]};
            default: load_ext = acc_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    state_d = req_err ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == last_idx_q) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = (state_q == ST_IDLE);
        o_busy      = (state_q != ST_IDLE);
        o_rsp_valid = (state_q == ST_RESP);
        o_rsp_err   = (state_q == ST_RESP) && err_q;
        o_rsp_rdata = '0;
        if ((state_q == ST_RESP) && !err_q && !we_q) begin
            o_rsp_rdata = load_ext;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            acc_q      <= '0;
            last_idx_q <= '0;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            zext_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (req_hs) begin
                addr_q     <= i_req_addr[NB_ADDR-1:0];
                wdata_q    <= i_req_wdata;
                acc_q      <= '0;
                // Size code doubles as the index of the last byte: B=0, H=1, W=3.
                last_idx_q <= i_req_bhw[1:0];
                cnt_q      <= '0;
                we_q       <= i_req_we;
                zext_q     <= i_req_bhw[2];
                err_q      <= req_err;
            end else if (state_q == ST_ACCESS) begin
                cnt_q <= cnt_q + 2'd1;
                if (!we_q) begin
                    acc_q <= {acc_q[NB_WIDTH-NB_DATA-1:0], mem[ram_addr]};
                end
            end else if ((state_q == ST_RESP) && i_rsp_ready) begin
                err_q <= 1'b0;
            end
        end
    end

    // Backing store has no reset: contents survive i_reset.
    always_ff @(posedge i_clk) begin
        if ((state_q == ST_ACCESS) && we_q) begin
            mem[ram_addr] <= wbyte;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_bhw;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] ref_mem [0:511];

    dmem_responder dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_we    (req_we),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .i_req_bhw   (req_bhw),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_err   (rsp_err),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_err(input logic [31:0] addr, input logic [2:0] bhw);
        bit e;
        e = (bhw[1:0] == 2'b10);
`ifdef DMEM_ALIGN_CHECK_EN
        if (bhw[1:0] == 2'b01 && addr[0] != 1'b0) e = 1'b1;
        if (bhw[1:0] == 2'b11 && addr[1:0] != 2'b00) e = 1'b1;
`endif
        return e;
    endfunction

    // Reference: big-endian byte array, nbytes from the size code, extension by plain masking.
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] bhw, input int hold, input bit noise,
                           output logic [31:0] got);
        int          nb;
        int          lat;
        int          exp_lat;
        bit          e;
        logic [31:0] exp_rd;
        logic [31:0] mask;
        nb = (bhw[1:0] == 2'b00) ? 1 : (bhw[1:0] == 2'b01) ? 2 : 4;
        e = is_err(addr, bhw);
        exp_lat = e ? 0 : nb;
        exp_rd = 32'h0;
        if (!e && !we) begin
            for (int i = 0; i < nb; i++) exp_rd = (exp_rd << 8) | 32'(ref_mem[(addr[8:0] + 9'(i))]);
            if (nb < 4) begin
                mask = (32'h1 << (8 * nb)) - 32'h1;
                if (!bhw[2] && exp_rd[8*nb-1]) exp_rd = exp_rd | ~mask;
            end
        end
        if (!e && we) begin
            for (int i = 0; i < nb; i++) ref_mem[addr[8:0] + 9'(i)] = 8'(wdata >> (8 * (nb - 1 - i)));
        end

        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_bhw   = bhw;
        check("req_ready_idle", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = noise ? 1'($urandom) : 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_bhw   = 3'($urandom);
        rsp_ready = noise ? 1'($urandom) : 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (noise) begin
                req_valid = 1'($urandom);
                req_addr  = $urandom;
                req_bhw   = 3'($urandom);
                if (!rsp_valid) rsp_ready = 1'($urandom);
            end
        end
        rsp_ready = 1'b0;
        check("rsp_latency", 32'(lat), 32'(exp_lat));
        check("rsp_err", 32'(rsp_err), 32'(e));
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("ready_low_busy", {30'h0, req_ready, busy}, 32'h1);
        got = rsp_rdata;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {30'h0, rsp_valid, req_ready}, 32'h2);
            check("hold_rdata", rsp_rdata, exp_rd);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("after_rsp", {rsp_rdata[29:0], rsp_valid, rsp_err}, 32'h0);
        check("after_rsp_idle", {30'h0, req_ready, busy}, 32'h2);
    endtask

    logic [31:0] got;
    logic [2:0]  rb;

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_bhw   = 3'b000;
        rsp_ready = 1'b0;
        #2;
        check("reset_outputs", {27'h0, req_ready, rsp_valid, rsp_err, busy, |rsp_rdata}, 32'h10);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int a = 0; a < 512; a += 4) run_req(1'b1, 32'(a), $urandom, 3'b011, 0, 1'b0, got);

        run_req(1'b1, 32'h010, 32'h11223344, 3'b011, 0, 1'b0, got);
        run_req(1'b0, 32'h010, 32'h0, 3'b011, 0, 1'b0, got);
        check("load_w_0x010", got, 32'h11223344);
        run_req(1'b0, 32'h011, 32'h0, 3'b100, 0, 1'b0, got);
        check("byte_0x011", got, 32'h22);
        run_req(1'b0, 32'h013, 32'h0, 3'b100, 0, 1'b0, got);
        check("byte_0x013", got, 32'h44);

        run_req(1'b1, 32'h020, 32'h00000080, 3'b000, 0, 1'b0, got);
        run_req(1'b0, 32'h020, 32'h0, 3'b000, 0, 1'b0, got);
        check("load_b_sext", got, 32'hFFFFFF80);
        run_req(1'b0, 32'h020, 32'h0, 3'b100, 0, 1'b0, got);
        check("load_b_zext", got, 32'h00000080);

        run_req(1'b1, 32'h1FF, 32'h0000BEEF, 3'b001, 0, 1'b0, got);
        run_req(1'b0, 32'h000, 32'h0, 3'b100, 0, 1'b0, got);
        check("wrap_byte_0x000", got, 32'hEF);
        run_req(1'b0, 32'h1FF, 32'h0, 3'b100, 0, 1'b0, got);
        check("wrap_byte_0x1ff", got, 32'hBE);
        run_req(1'b0, 32'h1FF, 32'h0, 3'b001, 0, 1'b0, got);
`ifndef DMEM_ALIGN_CHECK_EN
        check("load_h_wrap", got, 32'hFFFFBEEF);
`endif

        run_req(1'b0, 32'h010, 32'h0, 3'b010, 0, 1'b0, got);
        check("illegal_size", got, 32'h0);
        run_req(1'b1, 32'h010, 32'hDEADBEEF, 3'b010, 0, 1'b0, got);
        run_req(1'b0, 32'h010, 32'h0, 3'b111, 0, 1'b0, got);
        check("ram_unchanged", got, 32'h11223344);

        run_req(1'b0, 32'h002, 32'h0, 3'b011, 0, 1'b0, got);
        run_req(1'b0, 32'h010, 32'h0, 3'b011, 5, 1'b0, got);

        // Reset after the second byte of a word store has been written.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h100;
        req_wdata = 32'hA1B2C3D4;
        req_bhw   = 3'b011;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midstore_reset", {27'h0, req_ready, rsp_valid, rsp_err, busy, |rsp_rdata}, 32'h10);
        ref_mem[9'h100] = 8'hA1;
        ref_mem[9'h101] = 8'hB2;
        @(negedge clk);
        rst_n = 1'b1;
        run_req(1'b0, 32'h100, 32'h0, 3'b011, 0, 1'b0, got);
        check("partial_bytes_hi", {16'h0, got[31:16]}, 32'hA1B2);

        for (int n = 0; n < 300; n++) begin
            rb = 3'($urandom);
            run_req(1'($urandom), $urandom, $urandom, rb, $urandom_range(0, 3), 1'b1, got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
